dap_baud_generator: RTL and testbench



---
 rtl/dap_baud_generator_if.sv | 26 ++
 rtl/dap_baud_generator.sv | 134 +++++++++++++
 tb/tb_dap_baud_generator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dap_baud_generator_if.sv
// Register-window bus for the DAP baud generator: single-cycle write/read strobes
// with byte enables and a registered read-data return.
interface dap_baud_generator_if #(
  parameter int ADDR_WIDTH = 12
);
  // Strobe semantics: ahb_write_en / ahb_read_en are one-cycle pulses with no
  // back-pressure. A write commits on the clk edge ending the strobe cycle. Read
  // data appears on ahb_rdata the cycle after ahb_read_en and holds until the
  // next read.
  logic                  ahb_write_en;
  logic                  ahb_read_en;
  logic [ADDR_WIDTH-1:0] ahb_addr;
  logic [31:0]           ahb_wdata;
  logic [3:0]            ahb_byte_strobe;
  logic [31:0]           ahb_rdata;

  modport master (
    output ahb_write_en, ahb_read_en, ahb_addr, ahb_wdata, ahb_byte_strobe,
    input  ahb_rdata
  );

  modport slave (
    input  ahb_write_en, ahb_read_en, ahb_addr, ahb_wdata, ahb_byte_strobe,
    output ahb_rdata
  );
endinterface

// File: rtl/dap_baud_generator.sv
// Programmable serial-clock generator for the DAP SWD/JTAG sequencer: divides clk
// into sclk_out and emits drive (falling edge) and sampling strobes.
module dap_baud_generator #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sclk_in,
  dap_baud_generator_if.slave  bus,
  output logic                 sclk_out,
  output logic                 sclk_negedge,
  output logic                 sclk_sampling
);

  logic        en_q;
  logic [31:0] div_q;
  logic [16:0] cnt_q;
  logic [15:0] h_cur_q;
  logic [16:0] s_cur_q;

  logic        hit_ctrl;
  logic        hit_div;
  logic        en_next;
  logic [31:0] div_next;
  logic [15:0] h_new;
  logic [16:0] p_new;
  logic [16:0] s_new;
  logic [16:0] p_cur;
  logic        wrap;
  logic        start;
  logic        run;

  logic [16:0] cnt_d;
  logic [15:0] h_d;
  logic [16:0] s_d;
  logic        sclk_d;
  logic        neg_d;
  logic        samp_d;

  // sclk_in exists only for pin compatibility with sibling DAP blocks.
  logic unused_sclk_in;
  assign unused_sclk_in = sclk_in;

  assign hit_ctrl = (bus.ahb_addr == BASE_ADDR);
  assign hit_div  = (bus.ahb_addr == BASE_ADDR + ADDR_WIDTH'(4));

  always_comb begin
    en_next  = en_q;
    div_next = div_q;
    if (bus.ahb_write_en && hit_ctrl && bus.ahb_byte_strobe[0]) begin
      en_next = bus.ahb_wdata[0];
    end
    for (int b = 0; b < 4; b++) begin
      if (bus.ahb_write_en && hit_div && bus.ahb_byte_strobe[b]) begin
        div_next[b*8 +: 8] = bus.ahb_wdata[b*8 +: 8];
      end
    end
  end

  // Effective timing derived from the programmed DIV; loaded into the shadow
  // copy only at a period start so a mid-period update never produces a runt.
  always_comb begin
    h_new = (div_q[15:0] == 16'd0) ? 16'd1 : div_q[15:0];
    p_new = {h_new, 1'b0};
    s_new = ({1'b0, div_q[31:16]} > (p_new - 17'd1)) ? (p_new - 17'd1)
                                                     : {1'b0, div_q[31:16]};
  end

  assign p_cur = {h_cur_q, 1'b0};
  assign wrap  = (cnt_q == p_cur - 17'd1);
  assign start = en_next && !en_q;
  assign run   = en_next && en_q;

  always_comb begin
    cnt_d  = 17'd0;
    h_d    = h_cur_q;
    s_d    = s_cur_q;
    sclk_d = 1'b1;
    neg_d  = 1'b0;
    samp_d = 1'b0;
    if (start || (run && wrap)) begin
      cnt_d  = 17'd0;
      h_d    = h_new;
      s_d    = s_new;
      sclk_d = 1'b0;
      neg_d  = 1'b1;
      samp_d = (s_new == 17'd0);
    end else if (run) begin
      cnt_d  = cnt_q + 17'd1;
      sclk_d = (cnt_d >= {1'b0, h_cur_q});
      samp_d = (cnt_d == s_cur_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q          <= 1'b0;
      div_q         <= 32'h0001_0001;
      cnt_q         <= 17'd0;
      h_cur_q       <= 16'd1;
      s_cur_q       <= 17'd1;
      sclk_out      <= 1'b1;
      sclk_negedge  <= 1'b0;
      sclk_sampling <= 1'b0;
    end else begin
      en_q          <= en_next;
      div_q         <= div_next;
      cnt_q         <= cnt_d;
      h_cur_q       <= h_d;
      s_cur_q       <= s_d;
      sclk_out      <= sclk_d;
      sclk_negedge  <= neg_d;
      sclk_sampling <= samp_d;
    end
  end

  // Read mux samples pre-write register values, so a same-cycle write+read
  // returns the old contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.ahb_rdata <= 32'd0;
    end else if (bus.ahb_read_en) begin
      if (hit_ctrl) begin
        bus.ahb_rdata <= {31'd0, en_q};
      end else if (hit_div) begin
        bus.ahb_rdata <= div_q;
      end else begin
        bus.ahb_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dap_baud_generator.sv
// Directed bench for dap_baud_generator: register access, divider timing,
// shadowed DIV updates, enable/disable and asynchronous reset.
module tb_dap_baud_generator;

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_DIV  = 12'h004;

  logic clk;
  logic resetn;
  logic sclk_in;
  logic sclk_out;
  logic sclk_negedge;
  logic sclk_sampling;

  int checks = 0;
  int errors = 0;

  dap_baud_generator_if #(.ADDR_WIDTH(12)) bus ();

  dap_baud_generator #(
    .ADDR_WIDTH (12),
    .BASE_ADDR  (12'h000)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .sclk_in       (sclk_in),
    .bus           (bus),
    .sclk_out      (sclk_out),
    .sclk_negedge  (sclk_negedge),
    .sclk_sampling (sclk_sampling)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: the write happens in this cycle, returns at the next negedge.
  task automatic write_reg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb);
    bus.ahb_write_en    = 1'b1;
    bus.ahb_addr        = a;
    bus.ahb_wdata       = d;
    bus.ahb_byte_strobe = strb;
    @(negedge clk);
    bus.ahb_write_en    = 1'b0;
    bus.ahb_byte_strobe = 4'h0;
  endtask

  task automatic read_reg(input logic [11:0] a, output logic [31:0] d);
    bus.ahb_read_en = 1'b1;
    bus.ahb_addr    = a;
    @(negedge clk);
    bus.ahb_read_en = 1'b0;
    d = bus.ahb_rdata;
  endtask

  task automatic rw_same(input logic [11:0] a, input logic [31:0] wd, output logic [31:0] d);
    bus.ahb_write_en    = 1'b1;
    bus.ahb_read_en     = 1'b1;
    bus.ahb_addr        = a;
    bus.ahb_wdata       = wd;
    bus.ahb_byte_strobe = 4'hF;
    @(negedge clk);
    bus.ahb_write_en    = 1'b0;
    bus.ahb_read_en     = 1'b0;
    bus.ahb_byte_strobe = 4'h0;
    d = bus.ahb_rdata;
  endtask

  // Expected waveform for effective half-period h and sampling offset s,
  // starting at counter position phase.
  task automatic check_run(input string tag, input int n, input int h, input int s, input int phase);
    int p;
    int c;
    p = 2 * h;
    for (int i = 0; i < n; i++) begin
      c = (phase + i) % p;
      chk({tag, "_sclk"}, {31'd0, sclk_out},      {31'd0, (c >= h)});
      chk({tag, "_neg"},  {31'd0, sclk_negedge},  {31'd0, (c == 0)});
      chk({tag, "_samp"}, {31'd0, sclk_sampling}, {31'd0, (c == s)});
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_sclk"}, {31'd0, sclk_out},      32'd1);
      chk({tag, "_neg"},  {31'd0, sclk_negedge},  32'd0);
      chk({tag, "_samp"}, {31'd0, sclk_sampling}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    resetn              = 1'b0;
    sclk_in             = 1'b0;
    bus.ahb_write_en    = 1'b0;
    bus.ahb_read_en     = 1'b0;
    bus.ahb_addr        = 12'h000;
    bus.ahb_wdata       = 32'h0;
    bus.ahb_byte_strobe = 4'h0;

    // Reset state
    @(negedge clk);
    chk("rst_sclk", {31'd0, sclk_out}, 32'd1);
    chk("rst_neg", {31'd0, sclk_negedge}, 32'd0);
    chk("rst_samp", {31'd0, sclk_sampling}, 32'd0);
    chk("rst_rdata", bus.ahb_rdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    read_reg(A_CTRL, rd);
    chk("rst_ctrl", rd, 32'd0);
    read_reg(A_DIV, rd);
    chk("rst_div", rd, 32'h0001_0001);

    // Fastest divider: period 2
    write_reg(A_DIV, 32'h0001_0001, 4'hF);
    write_reg(A_CTRL, 32'h1, 4'hF);
    read_reg(A_CTRL, rd);
    chk("en_ctrl", rd, 32'd1);
    check_run("p2", 6, 1, 1, 1);

    // Period 8, sampling 5 after falling edge
    write_reg(A_CTRL, 32'h0, 4'hF);
    check_idle("dis1", 1);
    write_reg(A_DIV, 32'h0005_0004, 4'hF);
    write_reg(A_CTRL, 32'h1, 4'hF);
    check_run("p8", 16, 4, 5, 0);

    // SAMP=16 clamps to P-1=7
    write_reg(A_CTRL, 32'h0, 4'hF);
    write_reg(A_DIV, 32'h0010_0004, 4'hF);
    write_reg(A_CTRL, 32'h1, 4'hF);
    check_run("clamp", 16, 4, 7, 0);

    // DIV change mid-period: old timing completes, new starts at next fall
    check_run("mid_a", 3, 4, 7, 0);
    write_reg(A_DIV, 32'h0002_0002, 4'hF);
    check_run("mid_old", 4, 4, 7, 4);
    check_run("mid_new", 8, 2, 2, 0);

    // Byte-granular writes
    write_reg(A_CTRL, 32'h0, 4'hF);
    check_idle("dis2", 1);
    write_reg(A_DIV, 32'h0001_0001, 4'hF);
    write_reg(A_DIV, 32'h0000_0003, 4'b0001);
    read_reg(A_DIV, rd);
    chk("strb_lo", rd, 32'h0001_0003);
    write_reg(A_DIV, 32'hABCD_0000, 4'b1100);
    read_reg(A_DIV, rd);
    chk("strb_hi", rd, 32'hABCD_0003);

    // Writes outside the window change nothing
    write_reg(12'h084, 32'hFFFF_FFFF, 4'hF);
    write_reg(12'h088, 32'hFFFF_FFFF, 4'hF);
    read_reg(12'h084, rd);
    chk("oow_rd", rd, 32'd0);
    read_reg(A_CTRL, rd);
    chk("oow_ctrl", rd, 32'd0);
    read_reg(A_DIV, rd);
    chk("oow_div", rd, 32'hABCD_0003);
    check_idle("oow_idle", 1);
    chk("rdata_hold", bus.ahb_rdata, 32'hABCD_0003);

    // Simultaneous write and read return the old value
    rw_same(A_DIV, 32'h0005_0004, rd);
    chk("rw_old", rd, 32'hABCD_0003);
    read_reg(A_DIV, rd);
    chk("rw_new", rd, 32'h0005_0004);

    // Clear EN mid-period
    write_reg(A_CTRL, 32'h1, 4'hF);
    check_run("pre_stop", 3, 4, 5, 0);
    write_reg(A_CTRL, 32'h0, 4'hF);
    check_idle("stop", 10);

    // HALF=0 behaves as HALF=1, SAMP=0 coincides with the falling edge
    write_reg(A_DIV, 32'h0000_0000, 4'hF);
    write_reg(A_CTRL, 32'h1, 4'hF);
    check_run("half0", 4, 1, 0, 0);

    // Asynchronous reset mid-operation (currently at the falling-edge cycle)
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_sclk", {31'd0, sclk_out}, 32'd1);
    chk("arst_neg", {31'd0, sclk_negedge}, 32'd0);
    chk("arst_samp", {31'd0, sclk_sampling}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    read_reg(A_CTRL, rd);
    chk("arst_ctrl", rd, 32'd0);
    read_reg(A_DIV, rd);
    chk("arst_div", rd, 32'h0001_0001);
    check_idle("arst_idle", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
